pulse_req_queue: RTL and testbench

//  Write-side feeder for the cross-domain pulse synchronizer (sync_pulse / sync_ack).

---
 rtl/pulse_req_queue.sv | 96 +++++++++
 tb/tb_pulse_req_queue.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_req_queue.sv
// pulse_req_queue: write-side feeder for a cross-domain pulse synchronizer.
// Counts incoming event requests and issues them one at a time as single-cycle
// pulses on sig_out. Before each new pulse it waits for the synchronizer's busy
// round-trip to finish. Events arriving at a full queue are dropped and flagged.
`timescale 1ns/1ps
module pulse_req_queue #(
  parameter int CNT_WIDTH  = 4,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  busy_in,
  output logic                  sig_out,
  output logic [CNT_WIDTH-1:0]  pending,
  output logic                  overflow,
  input  logic                  clear_ovf,
  output logic [STAT_WIDTH-1:0] issued_cnt,
  output logic                  idle
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

  localparam logic [CNT_WIDTH-1:0] MAX = {CNT_WIDTH{1'b1}};

  state_t                r_state;
  logic                  r_sig_out;
  logic [CNT_WIDTH-1:0]  r_pending;
  logic                  r_overflow;
  logic [STAT_WIDTH-1:0] r_issued;

  logic w_dec;   // this edge enters ISSUE
  logic w_full;
  logic w_inc;   // request accepted into the queue
  logic w_drop;  // request lost: full and nothing leaving

  // Only issue from IDLE into a quiet synchronizer. This also covers a reset
  // in mid-handshake, because the synchronizer itself is not reset.
  assign w_dec  = (r_state == IDLE) && (r_pending != '0) && !busy_in;
  assign w_full = (r_pending == MAX);
  assign w_inc  = req && !(w_full && !w_dec);
  assign w_drop = req && w_full && !w_dec;

  // Handshake FSM; sig_out is a flop that is high exactly while in ISSUE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sig_out <= 1'b0;
    end else begin
      r_sig_out <= 1'b0;
      case (r_state)
        IDLE:    if (w_dec) begin
                   r_state   <= ISSUE;
                   r_sig_out <= 1'b1;
                 end
        ISSUE:   r_state <= WAIT_HI;
        WAIT_HI: if (busy_in)  r_state <= WAIT_LO;
        WAIT_LO: if (!busy_in) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Pending-event counter; saturates at MAX and never wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      case ({w_inc, w_dec})
        2'b10:   r_pending <= r_pending + CNT_WIDTH'(1);
        2'b01:   r_pending <= r_pending - CNT_WIDTH'(1);
        default: r_pending <= r_pending;
      endcase
    end
  end

  // Sticky drop flag; a new drop wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst)            r_overflow <= 1'b0;
    else if (w_drop)    r_overflow <= 1'b1;
    else if (clear_ovf) r_overflow <= 1'b0;
  end

  // Wrapping count of issued pulses
  always_ff @(posedge clk) begin
    if (rst)        r_issued <= '0;
    else if (w_dec) r_issued <= r_issued + STAT_WIDTH'(1);
  end

  assign sig_out    = r_sig_out;
  assign pending    = r_pending;
  assign overflow   = r_overflow;
  assign issued_cnt = r_issued;
  assign idle       = (r_state == IDLE) && (r_pending == '0);

endmodule

// File: tb/tb_pulse_req_queue.sv
// Bench for pulse_req_queue. Two DUTs: dut_a (CNT_WIDTH=4) and dut_b
// (CNT_WIDTH=2, used for the full-queue cases). dut_a's busy_in can come from
// a forced level, a fixed-length busy model, or a toggle/ack synchronizer
// model clocked at ~37 MHz. Each accepted request pushes its expected pulse
// number onto a queue. When a pulse appears, that number is popped and
// compared with issued_cnt.
`timescale 1ns/1ps
module tb_pulse_req_queue;

  localparam int BUSY_LEN = 6;

  logic clk = 1'b0, rclk = 1'b0;
  always #5    clk  = ~clk;
  always #13.5 rclk = ~rclk;

  logic rst = 1'b1, req_a = 1'b0, req_b = 1'b0, clear_ovf = 1'b0;
  logic busy_force = 1'b0, cnt_en = 1'b0, sync_en = 1'b0;
  logic busy_a, busy_b;
  logic sig_a, sig_b, ovf_a, ovf_b, idle_a, idle_b;
  logic [3:0]  pend_a;
  logic [1:0]  pend_b;
  logic [15:0] iss_a, iss_b;

  pulse_req_queue #(.CNT_WIDTH(4), .STAT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .busy_in(busy_a), .sig_out(sig_a),
    .pending(pend_a), .overflow(ovf_a), .clear_ovf(clear_ovf),
    .issued_cnt(iss_a), .idle(idle_a));

  pulse_req_queue #(.CNT_WIDTH(2), .STAT_WIDTH(16)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .busy_in(busy_b), .sig_out(sig_b),
    .pending(pend_b), .overflow(ovf_b), .clear_ovf(clear_ovf),
    .issued_cnt(iss_b), .idle(idle_b));

  // fixed-length busy model: busy rises the cycle after sig_out, lasts BUSY_LEN
  int cnt = 0;
  always @(posedge clk)
    if (cnt_en && sig_a) cnt <= BUSY_LEN;
    else if (cnt != 0)   cnt <= cnt - 1;

  // toggle/ack synchronizer model
  logic tog = 1'b0, ack_s1 = 1'b0, ack_s2 = 1'b0;
  logic rs1 = 1'b0, rs2 = 1'b0, rs3 = 1'b0;
  int   rd_pulses = 0;
  always @(posedge clk) begin
    if (sync_en && sig_a) tog <= ~tog;
    ack_s1 <= rs2;
    ack_s2 <= ack_s1;
  end
  always @(posedge rclk) begin
    rs1 <= tog;
    rs2 <= rs1;
    rs3 <= rs2;
    if (rs2 ^ rs3) rd_pulses <= rd_pulses + 1;
  end

  assign busy_a = busy_force | (cnt_en && cnt != 0) | (sync_en && (sig_a || tog != ack_s2));
  assign busy_b = busy_force;

  int n_vec = 0, n_bad = 0, cyc = 0, exp_seq = 0;
  int exp_q[$];
  int pulse_cyc[$];
  logic prev_sig = 1'b0;

  // advance one clock and sample; every pulse on dut_a is scored here
  task automatic step();
    int e;
    @(posedge clk); #1;
    cyc++;
    if (sig_a) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse cyc=%0d issued_cnt=%0d", cyc, iss_a);
      end else begin
        e = exp_q.pop_front();
        if (iss_a !== 16'(e)) begin
          n_bad++;
          $display("FAIL pulse_seq got %0d want %0d", iss_a, e);
        end
      end
      if (prev_sig) begin
        n_bad++;
        $display("FAIL pulse_width sig_out high two cycles at cyc=%0d", cyc);
      end
      pulse_cyc.push_back(cyc);
    end
    prev_sig = sig_a;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    pulse_cyc.delete();
    exp_seq = 0;
  endtask

  task automatic push_req_a();
    exp_seq++;
    exp_q.push_back(exp_seq);
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    for (int i = 0; i < max_cyc; i++) begin
      if (idle_a && !busy_a && exp_q.size() == 0) break;
      step();
    end
    n_vec++;
    if (!(idle_a && !busy_a && exp_q.size() == 0)) begin
      n_bad++;
      $display("FAIL %s_timeout idle=%b busy=%b outstanding=%0d want drained", tag, idle_a, busy_a, exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({sig_a, pend_a, ovf_a, iss_a, idle_a} !== {1'b0, 4'd0, 1'b0, 16'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_state sig=%b pend=%0d ovf=%b iss=%0d idle=%b want 0/0/0/0/1", sig_a, pend_a, ovf_a, iss_a, idle_a);
    end
  endtask

  task automatic test_single();
    do_reset();
    cnt_en = 1'b1;
    req_a = 1'b1; push_req_a();
    step();
    req_a = 1'b0;
    n_vec++;
    if (pend_a !== 4'd1 || sig_a !== 1'b0) begin
      n_bad++; $display("FAIL single_queued pend=%0d sig=%b want 1/0", pend_a, sig_a);
    end
    step();
    n_vec++;
    if (sig_a !== 1'b1 || pend_a !== 4'd0) begin
      n_bad++; $display("FAIL single_issue sig=%b pend=%0d want 1/0", sig_a, pend_a);
    end
    wait_idle(100, "single");
    n_vec++;
    if (iss_a !== 16'd1 || idle_a !== 1'b1 || pulse_cyc.size() != 1) begin
      n_bad++; $display("FAIL single_end iss=%0d idle=%b pulses=%0d want 1/1/1", iss_a, idle_a, pulse_cyc.size());
    end
  endtask

  task automatic test_burst();
    do_reset();
    cnt_en = 1'b1; busy_force = 1'b1;
    req_a = 1'b1;
    repeat (3) begin push_req_a(); step(); end
    req_a = 1'b0;
    repeat (3) step();
    n_vec++;
    if (pend_a !== 4'd3 || pulse_cyc.size() != 0) begin
      n_bad++; $display("FAIL burst_held pend=%0d pulses=%0d want 3/0", pend_a, pulse_cyc.size());
    end
    busy_force = 1'b0;
    wait_idle(200, "burst");
    n_vec++;
    if (iss_a !== 16'd3 || pulse_cyc.size() != 3) begin
      n_bad++; $display("FAIL burst_count iss=%0d pulses=%0d want 3/3", iss_a, pulse_cyc.size());
    end else begin
      // model busy rises one cycle after sig_out: ISSUE + WAIT_HI + BUSY_LEN + IDLE
      for (int i = 1; i < 3; i++) begin
        n_vec++;
        if (pulse_cyc[i] - pulse_cyc[i-1] != BUSY_LEN + 3) begin
          n_bad++; $display("FAIL burst_spacing got %0d want %0d", pulse_cyc[i] - pulse_cyc[i-1], BUSY_LEN + 3);
        end
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    busy_force = 1'b1;
    req_b = 1'b1;
    repeat (5) step();
    req_b = 1'b0;
    n_vec++;
    if (pend_b !== 2'd3 || ovf_b !== 1'b1) begin
      n_bad++; $display("FAIL ovf_set pend=%0d ovf=%b want 3/1", pend_b, ovf_b);
    end
    clear_ovf = 1'b1; step(); clear_ovf = 1'b0;
    n_vec++;
    if (ovf_b !== 1'b0) begin
      n_bad++; $display("FAIL ovf_clear ovf=%b want 0", ovf_b);
    end
    clear_ovf = 1'b1; req_b = 1'b1; step(); clear_ovf = 1'b0; req_b = 1'b0;
    n_vec++;
    if (ovf_b !== 1'b1 || pend_b !== 2'd3) begin
      n_bad++; $display("FAIL ovf_set_wins ovf=%b pend=%0d want 1/3", ovf_b, pend_b);
    end
    busy_force = 1'b0;
  endtask

  task automatic test_coincident();
    // at MAX on dut_b
    do_reset();
    busy_force = 1'b1;
    req_b = 1'b1;
    repeat (3) step();
    n_vec++;
    if (pend_b !== 2'd3) begin
      n_bad++; $display("FAIL max_fill pend=%0d want 3", pend_b);
    end
    busy_force = 1'b0;
    step();
    req_b = 1'b0;
    n_vec++;
    if (pend_b !== 2'd3 || ovf_b !== 1'b0 || sig_b !== 1'b1 || iss_b !== 16'd1) begin
      n_bad++; $display("FAIL max_coincident pend=%0d ovf=%b sig=%b iss=%0d want 3/0/1/1", pend_b, ovf_b, sig_b, iss_b);
    end
    // pending=2 on dut_a
    do_reset();
    cnt_en = 1'b1; busy_force = 1'b1;
    req_a = 1'b1;
    repeat (2) begin push_req_a(); step(); end
    busy_force = 1'b0;
    push_req_a();
    step();
    req_a = 1'b0;
    n_vec++;
    if (pend_a !== 4'd2 || sig_a !== 1'b1) begin
      n_bad++; $display("FAIL mid_coincident pend=%0d sig=%b want 2/1", pend_a, sig_a);
    end
    wait_idle(200, "coincident");
    n_vec++;
    if (iss_a !== 16'd3) begin
      n_bad++; $display("FAIL mid_issued iss=%0d want 3", iss_a);
    end
  endtask

  task automatic test_reset_busy();
    int early;
    do_reset();
    cnt_en = 1'b0; busy_force = 1'b0;
    req_a = 1'b1; push_req_a(); step(); req_a = 1'b0;
    step();                      // ISSUE
    busy_force = 1'b1;
    step();                      // WAIT_HI
    step();                      // WAIT_LO
    do_reset();                  // busy_in still high
    n_vec++;
    if ({sig_a, pend_a, ovf_a, iss_a, idle_a} !== {1'b0, 4'd0, 1'b0, 16'd0, 1'b1}) begin
      n_bad++; $display("FAIL rst_busy_state sig=%b pend=%0d ovf=%b iss=%0d idle=%b want 0/0/0/0/1", sig_a, pend_a, ovf_a, iss_a, idle_a);
    end
    req_a = 1'b1; push_req_a(); step(); req_a = 1'b0;
    early = 0;
    repeat (4) begin step(); if (sig_a) early++; end
    n_vec++;
    if (early != 0 || pend_a !== 4'd1) begin
      n_bad++; $display("FAIL rst_busy_hold early_pulses=%0d pend=%0d want 0/1", early, pend_a);
    end
    cnt_en = 1'b1; busy_force = 1'b0;
    step();
    n_vec++;
    if (sig_a !== 1'b1) begin
      n_bad++; $display("FAIL rst_busy_release sig=%b want 1", sig_a);
    end
    wait_idle(100, "rst_busy");
    n_vec++;
    if (iss_a !== 16'd1) begin
      n_bad++; $display("FAIL rst_busy_issued iss=%0d want 1", iss_a);
    end
  endtask

  task automatic test_sync_integration();
    int rd0;
    do_reset();
    cnt_en = 1'b0; busy_force = 1'b0; sync_en = 1'b1;
    rd0 = rd_pulses;
    for (int i = 0; i < 20; i++) begin
      req_a = 1'b1; push_req_a(); step(); req_a = 1'b0;
      repeat ($urandom_range(20, 5)) step();
    end
    wait_idle(3000, "sync");
    repeat (20) step();
    n_vec++;
    if (rd_pulses - rd0 != 20) begin
      n_bad++; $display("FAIL sync_rd_pulses got %0d want 20", rd_pulses - rd0);
    end
    n_vec++;
    if (ovf_a !== 1'b0 || iss_a !== 16'd20) begin
      n_bad++; $display("FAIL sync_end ovf=%b iss=%0d want 0/20", ovf_a, iss_a);
    end
    sync_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_coincident();
    test_reset_busy();
    test_sync_integration();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
